// File: rtl/count_mon_pkg.sv
// rtl/count_mon_pkg.sv - shared types for the count wrap monitor
package count_mon_pkg;

    typedef enum logic [1:0] {
        STEP_HOLD,
        STEP_UP,
        STEP_DOWN,
        STEP_JUMP
    } step_e;

    typedef enum logic {
        UNPRIMED,
        TRACK
    } mon_state_e;

endpackage

// File: rtl/count_wrap_monitor_if.sv
// rtl/count_wrap_monitor_if.sv - sample/threshold/status bundle of the count wrap monitor
interface count_wrap_monitor_if #(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 4
);
    logic                       sample_en;
    logic [WIDTH-1:0]           count_in;
    logic [WIDTH+EXT_WIDTH-1:0] thresh;
    logic                       irq_clr;
    logic [WIDTH+EXT_WIDTH-1:0] ext_count;
    logic                       wrap_up;
    logic                       wrap_down;
    logic                       jump;
    logic                       over_thresh;
    logic                       irq;

    modport master (
        output sample_en, count_in, thresh, irq_clr,
        input  ext_count, wrap_up, wrap_down, jump, over_thresh, irq
    );

    modport slave (
        input  sample_en, count_in, thresh, irq_clr,
        output ext_count, wrap_up, wrap_down, jump, over_thresh, irq
    );
endinterface

// File: rtl/count_step_classify.sv
// rtl/count_step_classify.sv - classifies one counter step as hold, +1, -1 or jump
module count_step_classify
    import count_mon_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] prev,
    input  logic [WIDTH-1:0] cur,
    output step_e            step,
    output logic             is_wrap_up,
    output logic             is_wrap_down
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] MAX = '1;

    logic [WIDTH-1:0] prev_inc;
    logic [WIDTH-1:0] prev_dec;

    assign prev_inc = prev + ONE;
    assign prev_dec = prev - ONE;

    always_comb begin
        step         = STEP_HOLD;
        is_wrap_up   = 1'b0;
        is_wrap_down = 1'b0;
        if (cur == prev) begin
            step = STEP_HOLD;
        end else if (cur == prev_inc) begin
            step       = STEP_UP;
            is_wrap_up = (prev == MAX);
        end else if (cur == prev_dec) begin
            step         = STEP_DOWN;
            is_wrap_down = (prev == '0);
        end else begin
            step = STEP_JUMP;
        end
    end
endmodule

// File: rtl/count_wrap_monitor.sv
// rtl/count_wrap_monitor.sv - extends a small up/down counter with a wrap word and threshold irq
module count_wrap_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int EXT_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    count_wrap_monitor_if.slave  mon
);
    localparam logic [EXT_WIDTH-1:0] HI_ONE = EXT_WIDTH'(1);

    mon_state_e           state_q, state_d;
    logic [WIDTH-1:0]     last_low_q, last_low_d;
    logic [EXT_WIDTH-1:0] hi_q, hi_d;
    logic                 wrap_up_q, wrap_up_d;
    logic                 wrap_down_q, wrap_down_d;
    logic                 jump_q, jump_d;
    logic                 over_q, over_d;
    logic                 over_prev_q, over_prev_d;
    logic                 irq_q, irq_d;

    step_e step;
    logic  is_wrap_up;
    logic  is_wrap_down;

    count_step_classify #(.WIDTH(WIDTH)) u_classify (
        .prev         (last_low_q),
        .cur          (mon.count_in),
        .step         (step),
        .is_wrap_up   (is_wrap_up),
        .is_wrap_down (is_wrap_down)
    );

    always_comb begin
        state_d     = state_q;
        last_low_d  = last_low_q;
        hi_d        = hi_q;
        wrap_up_d   = 1'b0;
        wrap_down_d = 1'b0;
        jump_d      = 1'b0;
        if (mon.sample_en) begin
            last_low_d = mon.count_in;
            if (state_q == UNPRIMED) begin
                state_d = TRACK;
            end else begin
                case (step)
                    STEP_UP: if (is_wrap_up) begin
                        hi_d      = hi_q + HI_ONE;
                        wrap_up_d = 1'b1;
                    end
                    STEP_DOWN: if (is_wrap_down) begin
                        hi_d        = hi_q - HI_ONE;
                        wrap_down_d = 1'b1;
                    end
                    STEP_JUMP: jump_d = 1'b1;
                    default:   ;
                endcase
            end
        end
        // Compare the value ext_count is about to take so over_thresh lines up with it.
        over_d      = ({hi_d, last_low_d} >= mon.thresh);
        over_prev_d = over_q;
        irq_d       = (over_q & ~over_prev_q) | (irq_q & ~mon.irq_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= UNPRIMED;
            last_low_q  <= '0;
            hi_q        <= '0;
            wrap_up_q   <= 1'b0;
            wrap_down_q <= 1'b0;
            jump_q      <= 1'b0;
            over_q      <= 1'b0;
            over_prev_q <= 1'b0;
            irq_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_low_q  <= last_low_d;
            hi_q        <= hi_d;
            wrap_up_q   <= wrap_up_d;
            wrap_down_q <= wrap_down_d;
            jump_q      <= jump_d;
            over_q      <= over_d;
            over_prev_q <= over_prev_d;
            irq_q       <= irq_d;
        end
    end

    assign mon.ext_count   = {hi_q, last_low_q};
    assign mon.wrap_up     = wrap_up_q;
    assign mon.wrap_down   = wrap_down_q;
    assign mon.jump        = jump_q;
    assign mon.over_thresh = over_q;
    assign mon.irq         = irq_q;
endmodule

// File: tb/tb_count_wrap_monitor.sv
// tb/tb_count_wrap_monitor.sv - directed self-checking bench for count_wrap_monitor
module tb_count_wrap_monitor;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    count_wrap_monitor_if #(.WIDTH(4), .EXT_WIDTH(4)) mon_if ();

    count_wrap_monitor #(.WIDTH(4), .EXT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .mon (mon_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [7:0] ext, input logic wu,
                             input logic wd, input logic jp, input logic ov, input logic irq);
        check({tag, ".ext_count"},   mon_if.ext_count, ext);
        check({tag, ".wrap_up"},     {7'd0, mon_if.wrap_up}, {7'd0, wu});
        check({tag, ".wrap_down"},   {7'd0, mon_if.wrap_down}, {7'd0, wd});
        check({tag, ".jump"},        {7'd0, mon_if.jump}, {7'd0, jp});
        check({tag, ".over_thresh"}, {7'd0, mon_if.over_thresh}, {7'd0, ov});
        check({tag, ".irq"},         {7'd0, mon_if.irq}, {7'd0, irq});
    endtask

    task automatic do_sample(input logic [3:0] v);
        mon_if.count_in  = v;
        mon_if.sample_en = 1'b1;
        @(posedge clk);
        #1;
        mon_if.sample_en = 1'b0;
    endtask

    task automatic idle(input logic clr);
        mon_if.irq_clr = clr;
        @(posedge clk);
        #1;
        mon_if.irq_clr = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        mon_if.sample_en = 1'b0;
        mon_if.count_in  = 4'd0;
        mon_if.thresh    = 8'h12;
        mon_if.irq_clr   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_all("reset", 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Wrap up
        do_sample(4'd0);
        check_all("prime0", 8'h00, 0, 0, 0, 0, 0);
        for (int i = 1; i < 16; i++) begin
            do_sample(4'(i));
            check("up.ext_count", mon_if.ext_count, 8'(i));
            check("up.wrap_up", {7'd0, mon_if.wrap_up}, 8'd0);
        end
        do_sample(4'd0);
        check_all("wrap15to0", 8'h10, 1, 0, 0, 0, 0);
        do_sample(4'd1);
        check_all("up11", 8'h11, 0, 0, 0, 0, 0);
        do_sample(4'd2);
        check_all("up12", 8'h12, 0, 0, 0, 1, 0);
        idle(1'b0);
        check_all("irq_set", 8'h12, 0, 0, 0, 1, 1);

        // Wrap down
        do_sample(4'd1);
        check_all("dn11", 8'h11, 0, 0, 0, 0, 1);
        do_sample(4'd0);
        check_all("dn10", 8'h10, 0, 0, 0, 0, 1);
        do_sample(4'd15);
        check_all("wrap0to15", 8'h0F, 0, 1, 0, 0, 1);
        do_sample(4'd14);
        check_all("dn0e", 8'h0E, 0, 0, 0, 0, 1);

        // Jump from 0x13
        do_sample(4'd15);
        do_sample(4'd0);
        check_all("rewrap", 8'h10, 1, 0, 0, 0, 1);
        do_sample(4'd1);
        do_sample(4'd2);
        do_sample(4'd3);
        check_all("at13", 8'h13, 0, 0, 0, 1, 1);
        do_sample(4'd10);
        check_all("jump1a", 8'h1A, 0, 0, 1, 1, 1);

        // Clear versus set
        idle(1'b1);
        check_all("clr_lone1", 8'h1A, 0, 0, 0, 1, 0);
        do_sample(4'd0);
        check_all("drop10", 8'h10, 0, 0, 1, 0, 0);
        do_sample(4'd2);
        check_all("rise12", 8'h12, 0, 0, 1, 1, 0);
        idle(1'b1);
        check_all("set_wins", 8'h12, 0, 0, 0, 1, 1);
        idle(1'b1);
        check_all("clr_lone2", 8'h12, 0, 0, 0, 1, 0);

        // Gating
        for (int i = 0; i < 4; i++) begin
            mon_if.count_in = 4'(5 + 3 * i);
            @(posedge clk);
            #1;
            check_all("gated", 8'h12, 0, 0, 0, 1, 0);
        end

        // Reset mid-operation
        do_sample(4'd15);
        check_all("jump1f", 8'h1F, 0, 0, 1, 1, 0);
        do_sample(4'd0);
        check_all("wrap20", 8'h20, 1, 0, 0, 1, 0);
        do_sample(4'd3);
        check_all("jump23", 8'h23, 0, 0, 1, 1, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 8'h00, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        do_sample(4'd7);
        check_all("reprime7", 8'h07, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
